// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared definitions for the AXI4-Lite control register bank.
// Includes response codes, the default window base, register roles and the byte-merge helper.
package axi_lite_reg_bank_pkg;

  localparam logic [1:0]  RESP_OKAY         = 2'b00;
  localparam logic [1:0]  RESP_SLVERR       = 2'b10;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h43C8_0000;

  localparam int unsigned REG_COMMAND    = 0;
  localparam int unsigned REG_CNT_RESET  = 5;
  localparam int unsigned REG_CNT_START  = 6;
  localparam int unsigned REG_STATE_LOCK = 7;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_t;

  function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write channel control: latches AW and W independently, decodes the
// target register, issues a one-cycle commit, then holds B until it is accepted.
module axi_lite_wr_ctrl
  import axi_lite_reg_bank_pkg::*;
#(
  parameter int unsigned           NUM_REGS  = 32,
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [DATA_W-1:0]           s_wdata,
  input  logic [DATA_W/8-1:0]         s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  output logic                        wr_en,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W/8-1:0]         wr_strb
);

  localparam int unsigned       LSB       = $clog2(DATA_W/8);
  localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(NUM_REGS*DATA_W/8);

  wr_state_t             state, state_d;
  logic                  aw_q, aw_d, w_q, w_d;
  logic [1:0]            bresp_d;
  logic [ADDR_W-1:0]     awaddr_q, off;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  commit, wr_err;

  assign s_awready = (state == WR_COLLECT) && !aw_q;
  assign s_wready  = (state == WR_COLLECT) && !w_q;
  assign s_bvalid  = (state == WR_RESP);

  assign off     = awaddr_q - BASE_ADDR;
  assign wr_idx  = awaddr_q[LSB +: IDX_W];
  assign wr_err  = (off >= WIN_BYTES) || RO_MASK[wr_idx];
  assign commit  = (state == WR_COLLECT) && aw_q && w_q;
  assign wr_en   = commit && !wr_err;
  assign wr_data = wdata_q;
  assign wr_strb = wstrb_q;

  always_comb begin
    state_d = state;
    aw_d    = aw_q;
    w_d     = w_q;
    bresp_d = s_bresp;
    unique case (state)
      WR_COLLECT: begin
        if (s_awvalid && s_awready) aw_d = 1'b1;
        if (s_wvalid && s_wready)   w_d  = 1'b1;
        if (commit) begin
          state_d = WR_RESP;
          aw_d    = 1'b0;
          w_d     = 1'b0;
          bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      WR_RESP: begin
        if (s_bready) state_d = WR_COLLECT;
      end
      default: state_d = WR_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WR_COLLECT;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      s_bresp <= RESP_OKAY;
    end else begin
      state   <= state_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      s_bresp <= bresp_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (s_awvalid && s_awready) awaddr_q <= s_awaddr;
      if (s_wvalid && s_wready) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// Parametrised AXI4-Lite register bank with read-only status words, self-clearing
// pulse registers and a per-register write strobe. The read path lives here.
module axi_lite_reg_bank
  import axi_lite_reg_bank_pkg::*;
#(
  parameter int unsigned                 NUM_REGS   = 32,
  parameter int unsigned                 DATA_W     = 32,
  parameter int unsigned                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]           BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter logic [NUM_REGS-1:0]         RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]         PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  input  logic [NUM_REGS*DATA_W-1:0]   status_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned       LSB       = $clog2(DATA_W/8);
  localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
  localparam int unsigned       STRB_W    = DATA_W/8;
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(NUM_REGS*DATA_W/8);

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] status_w [NUM_REGS];
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data, merged;
  logic [STRB_W-1:0] wr_strb;
  logic [ADDR_W-1:0] rd_off;
  logic              rd_err;

  axi_lite_wr_ctrl #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_wr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
  );

  always_comb begin
    merged = regs[wr_idx];
    for (int unsigned b = 0; b < STRB_W; b++)
      merged[b*8 +: 8] = strb_merge(regs[wr_idx][b*8 +: 8], wr_data[b*8 +: 8], wr_strb[b]);
  end

  always_comb begin
    regs_o   = '0;
    status_w = '{default: '0};
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs[i];
      status_w[i]                = status_i[i*DATA_W +: DATA_W];
    end
  end

  // A pulse register is cleared the cycle after its strobe, unless rewritten in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pulse_o <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else begin
      wr_pulse_o <= '0;
      if (wr_en) wr_pulse_o[wr_idx] <= 1'b1;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i)))
          regs[i] <= merged;
        else if (PULSE_MASK[i] && wr_pulse_o[i])
          regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_off    = s_araddr - BASE_ADDR;
  assign rd_idx    = s_araddr[LSB +: IDX_W];
  assign rd_err    = (rd_off >= WIN_BYTES);
  assign s_arready = !s_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      if (rd_err) begin
        s_rdata <= '0;
        s_rresp <= RESP_SLVERR;
      end else begin
        s_rdata <= RO_MASK[rd_idx] ? status_w[rd_idx] : regs[rd_idx];
        s_rresp <= RESP_OKAY;
      end
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: directed scenarios plus randomized
// AXI-Lite traffic checked against an array-based model of the register window.
module tb_axi_lite_reg_bank;
  import axi_lite_reg_bank_pkg::*;

  localparam int unsigned    NR   = 8;
  localparam int unsigned    DW   = 32;
  localparam logic [31:0]    BASE = 32'h43C8_0000;
  localparam logic [NR-1:0]  RO   = 8'b0000_1000;
  localparam logic [NR-1:0]  PM   = 8'b0010_0000;
  localparam logic [NR*DW-1:0] RST_IMG = {32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};

  logic clk, rst;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [NR*DW-1:0] status_i, regs_o;
  logic [NR-1:0]    wr_pulse_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] model [NR];

  axi_lite_reg_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(32), .BASE_ADDR(BASE),
    .RO_MASK(RO), .PULSE_MASK(PM), .RESET_VAL(RST_IMG)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .status_i(status_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (s[b]) m = m | (32'hFF << (8*b));
    return m;
  endfunction

  function automatic logic [255:0] model_img();
    logic [255:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RST_IMG[i*32 +: 32];
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly);
    logic [31:0] off;
    bit in_win, ok, aw_done, w_done, hs_aw, hs_w, hs_b;
    int unsigned idx, c;
    logic [NR-1:0] exp_pulse;
    off    = addr - BASE;
    in_win = off < 32'(NR*4);
    idx    = in_win ? (off >> 2) : 0;
    ok     = in_win && !RO[idx];
    if (ok) model[idx] = (model[idx] & ~byte_mask(strb)) | (data & byte_mask(strb));
    exp_pulse = ok ? (NR'(1) << idx) : '0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c <= 40) begin
      s_awvalid = !aw_done && (c >= aw_dly);
      s_wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      check_eq("wr_bvalid_before_commit", 256'(s_bvalid), 256'(0));
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      @(posedge clk); #1;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      c++;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) begin
      check_eq("wr_handshake_timeout", 256'(aw_done && w_done), 256'(1));
      return;
    end
    @(negedge clk);
    check_eq("wr_commit_cycle_bvalid", 256'(s_bvalid), 256'(0));
    @(posedge clk); #1;
    c = 0; hs_b = 0;
    while (!hs_b && c <= 40) begin
      s_bready = (c >= b_dly);
      @(negedge clk);
      check_eq("wr_bvalid", 256'(s_bvalid), 256'(1));
      check_eq("wr_bresp", 256'(s_bresp), 256'(ok ? RESP_OKAY : RESP_SLVERR));
      check_eq("wr_awready_hold", 256'(s_awready), 256'(0));
      check_eq("wr_wready_hold", 256'(s_wready), 256'(0));
      if (c == 0) begin
        check_eq("wr_pulse", 256'(wr_pulse_o), 256'(exp_pulse));
        check_eq("wr_regs", 256'(regs_o), model_img());
      end else begin
        check_eq("wr_pulse_one_cycle", 256'(wr_pulse_o), 256'(0));
      end
      hs_b = s_bready && s_bvalid;
      @(posedge clk); #1;
      c++;
    end
    s_bready = 0;
    if (!hs_b) check_eq("wr_bready_timeout", 256'(hs_b), 256'(1));
    if (ok && PM[idx]) model[idx] = RST_IMG[idx*32 +: 32];
    @(negedge clk);
    check_eq("wr_awready_back", 256'(s_awready), 256'(1));
    check_eq("wr_wready_back", 256'(s_wready), 256'(1));
    check_eq("wr_bvalid_done", 256'(s_bvalid), 256'(0));
    check_eq("wr_pulse_after", 256'(wr_pulse_o), 256'(0));
    check_eq("wr_regs_after", 256'(regs_o), model_img());
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int unsigned ar_dly, input int unsigned r_dly);
    logic [31:0] off, exp_data;
    logic [1:0]  exp_resp;
    bit in_win, hs;
    int unsigned idx, c;
    off    = addr - BASE;
    in_win = off < 32'(NR*4);
    idx    = in_win ? (off >> 2) : 0;
    if (!in_win) begin
      exp_data = '0; exp_resp = RESP_SLVERR;
    end else begin
      exp_data = RO[idx] ? status_i[idx*32 +: 32] : model[idx];
      exp_resp = RESP_OKAY;
    end
    s_araddr = addr; c = 0; hs = 0;
    while (!hs && c <= 40) begin
      s_arvalid = (c >= ar_dly);
      @(negedge clk);
      check_eq("rd_rvalid_idle", 256'(s_rvalid), 256'(0));
      hs = s_arvalid && s_arready;
      @(posedge clk); #1;
      c++;
    end
    s_arvalid = 0;
    if (!hs) begin
      check_eq("rd_ar_timeout", 256'(hs), 256'(1));
      return;
    end
    c = 0; hs = 0;
    while (!hs && c <= 40) begin
      s_rready = (c >= r_dly);
      @(negedge clk);
      check_eq("rd_rvalid", 256'(s_rvalid), 256'(1));
      check_eq("rd_rdata", 256'(s_rdata), 256'(exp_data));
      check_eq("rd_rresp", 256'(s_rresp), 256'(exp_resp));
      check_eq("rd_arready_hold", 256'(s_arready), 256'(0));
      hs = s_rready && s_rvalid;
      @(posedge clk); #1;
      c++;
    end
    s_rready = 0;
    if (!hs) check_eq("rd_r_timeout", 256'(hs), 256'(1));
    @(negedge clk);
    check_eq("rd_arready_back", 256'(s_arready), 256'(1));
    check_eq("rd_rvalid_done", 256'(s_rvalid), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0; status_i = '0;
    model_reset();

    @(negedge clk);
    check_eq("rst_reg0", 256'(regs_o[31:0]), 256'(32'hDEAD_BEEF));
    check_eq("rst_regs", 256'(regs_o), 256'(RST_IMG));
    check_eq("rst_arready", 256'(s_arready), 256'(1));
    check_eq("rst_awready", 256'(s_awready), 256'(1));
    check_eq("rst_wready", 256'(s_wready), 256'(1));
    check_eq("rst_bvalid", 256'(s_bvalid), 256'(0));
    check_eq("rst_rvalid", 256'(s_rvalid), 256'(0));
    check_eq("rst_pulse", 256'(wr_pulse_o), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    axi_write(BASE + 32'h08, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    axi_write(BASE + 32'h08, 32'h1234_5678, 4'b0011, 0, 0, 0);
    check_eq("strobe_merge_reg2", 256'(regs_o[95:64]), 256'(32'hAABB_5678));

    axi_write(BASE + 32'h10, 32'h0F0F_5555, 4'hF, 3, 0, 4);

    status_i[127:96] = 32'hCAFE_0001;
    axi_read(BASE + 32'h0C, 0, 0);
    axi_write(BASE + 32'h0C, 32'h1111_2222, 4'hF, 0, 0, 1);
    axi_read(BASE + 32'(NR*4), 1, 2);

    axi_write(BASE + 32'h14, 32'h0000_0001, 4'hF, 0, 0, 0);

    // Read capture and write commit of reg 1 in the same cycle.
    s_awaddr = BASE + 32'h04; s_wdata = 32'h7; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_araddr = BASE + 32'h04;
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 1;
    @(posedge clk); #1;
    s_arvalid = 0;
    @(negedge clk);
    check_eq("rw_same_rvalid", 256'(s_rvalid), 256'(1));
    check_eq("rw_same_old_value", 256'(s_rdata), 256'(model[1]));
    check_eq("rw_same_bvalid", 256'(s_bvalid), 256'(1));
    model[1] = 32'h7;
    check_eq("rw_same_regs", 256'(regs_o), model_img());
    @(posedge clk); #1;
    s_bready = 1; s_rready = 1;
    @(posedge clk); #1;
    s_bready = 0; s_rready = 0;
    @(posedge clk); #1;
    axi_read(BASE + 32'h04, 0, 0);

    // Reset with a read response pending and AW latched.
    s_araddr = BASE; s_arvalid = 1;
    @(posedge clk); #1;
    s_arvalid = 0; s_awaddr = BASE + 32'h08; s_awvalid = 1;
    @(posedge clk); #1;
    s_awvalid = 0;
    @(negedge clk);
    check_eq("pre_rst_rvalid", 256'(s_rvalid), 256'(1));
    check_eq("pre_rst_aw_latched", 256'(s_awready), 256'(0));
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rvalid", 256'(s_rvalid), 256'(0));
    check_eq("arst_bvalid", 256'(s_bvalid), 256'(0));
    check_eq("arst_arready", 256'(s_arready), 256'(1));
    check_eq("arst_awready", 256'(s_awready), 256'(1));
    check_eq("arst_wready", 256'(s_wready), 256'(1));
    check_eq("arst_regs", 256'(regs_o), 256'(RST_IMG));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_write(BASE + 32'h08, 32'h5A5A_1234, 4'hF, 2, 0, 1);
    axi_read(BASE + 32'h08, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] addr;
      int unsigned sel;
      for (int i = 0; i < NR; i++) status_i[i*32 +: 32] = $urandom();
      sel = $urandom_range(9, 0);
      if (sel < NR) addr = BASE + 32'(sel*4) + 32'($urandom_range(3, 0));
      else if (sel == NR) addr = BASE + 32'(NR*4) + 32'($urandom_range(64, 0) * 4);
      else addr = BASE - 32'($urandom_range(16, 1) * 4);
      if ($urandom_range(1, 0) == 1)
        axi_write(addr, $urandom(), 4'($urandom_range(15, 0)),
                  $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      else
        axi_read(addr, $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
